// File: rtl/calc_pkg.sv
// Shared constants and state encoding for the calc result transmit path.
package calc_pkg;

    localparam int         RAH_PACKET_WIDTH = 48;
    localparam logic [7:0] HDR_TAG          = 8'hA5;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HDR  = 2'd1,
        DATA = 2'd2
    } state_t;

endpackage

// File: rtl/calc_result_fifo.sv
// Result buffer: power-of-two FIFO that accepts a push on a full cycle when a pop frees a slot.
module calc_result_fifo #(
    parameter int WIDTH = 48,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic                       pop,
    input  logic [WIDTH-1:0]           din,
    output logic [WIDTH-1:0]           dout,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       full,
    output logic                       empty
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Storage carries no reset; occupancy is tracked solely by the pointers and count.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

    assign dout  = mem[rd_ptr];
    assign full  = (count == CW'(DEPTH));
    assign empty = (count == '0);

endmodule

// File: rtl/calc_result_tx.sv
// Sends each buffered calc result to the RAH write FIFO as a header packet followed by a data packet.
module calc_result_tx #(
    parameter int         RAH_PACKET_WIDTH = calc_pkg::RAH_PACKET_WIDTH,
    parameter int         DEPTH            = 4,
    parameter logic [7:0] HDR_TAG          = calc_pkg::HDR_TAG
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [RAH_PACKET_WIDTH-1:0] res_data,
    input  logic                        res_wren,
    input  logic                        wr_full,
    output logic [RAH_PACKET_WIDTH-1:0] wr_data,
    output logic                        wr_en,
    output logic                        buf_full,
    output logic                        overflow,
    output logic [15:0]                 seq
);

    localparam int CW = $clog2(DEPTH+1);

    calc_pkg::state_t            state;
    logic                        push;
    logic                        pop;
    logic                        fifo_full;
    logic                        fifo_empty;
    logic [RAH_PACKET_WIDTH-1:0] head;
    logic [CW-1:0]               count;

    // Tag in the top byte, sequence number below it, zero padding in the low bits.
    function automatic logic [RAH_PACKET_WIDTH-1:0] hdr_word(input logic [15:0] s);
        logic [RAH_PACKET_WIDTH-1:0] w;
        w = RAH_PACKET_WIDTH'({HDR_TAG, s});
        return w << (RAH_PACKET_WIDTH - 24);
    endfunction

    assign push     = res_wren && !rst;
    assign pop      = (state == calc_pkg::DATA) && !wr_full && !rst;
    assign buf_full = (count == CW'(DEPTH));

    calc_result_fifo #(
        .WIDTH (RAH_PACKET_WIDTH),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .din   (res_data),
        .dout  (head),
        .count (count),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= calc_pkg::IDLE;
            wr_en    <= 1'b0;
            wr_data  <= '0;
            seq      <= 16'd0;
            overflow <= 1'b0;
        end else begin
            wr_en <= 1'b0;
            if (res_wren && fifo_full && !pop) overflow <= 1'b1;
            // Every packet is gated on the wr_full sampled at the same edge that registers wr_en.
            case (state)
                calc_pkg::IDLE: begin
                    if (!fifo_empty && !wr_full) state <= calc_pkg::HDR;
                end
                calc_pkg::HDR: begin
                    if (!wr_full) begin
                        wr_en   <= 1'b1;
                        wr_data <= hdr_word(seq);
                        state   <= calc_pkg::DATA;
                    end
                end
                calc_pkg::DATA: begin
                    if (!wr_full) begin
                        wr_en   <= 1'b1;
                        wr_data <= head;
                        seq     <= seq + 16'd1;
                        state   <= calc_pkg::IDLE;
                    end
                end
                default: state <= calc_pkg::IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_calc_result_tx.sv
// Directed bench for calc_result_tx with hand-computed packet expectations.
module tb_calc_result_tx;

    logic        clk;
    logic        rst;
    logic [47:0] res_data;
    logic        res_wren;
    logic        wr_full;
    logic [47:0] wr_data;
    logic        wr_en;
    logic        buf_full;
    logic        overflow;
    logic [15:0] seq;

    int checks   = 0;
    int failures = 0;
    logic [47:0] pkts[$];

    calc_result_tx dut (
        .clk      (clk),
        .rst      (rst),
        .res_data (res_data),
        .res_wren (res_wren),
        .wr_full  (wr_full),
        .wr_data  (wr_data),
        .wr_en    (wr_en),
        .buf_full (buf_full),
        .overflow (overflow),
        .seq      (seq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [47:0] hdr(input logic [15:0] s);
        return {8'hA5, s, 24'h000000};
    endfunction

    task automatic collect(input int n, input int budget, output int got);
        pkts.delete();
        got = 0;
        for (int c = 0; c < budget && got < n; c++) begin
            step();
            if (wr_en) begin
                pkts.push_back(wr_data);
                got++;
            end
        end
    endtask

    task automatic check_pkt(input string tag, input int idx, input logic [47:0] exp);
        if (idx < pkts.size()) check_eq(tag, {16'h0, pkts[idx]}, {16'h0, exp});
        else check_eq(tag, 64'hDEAD, {16'h0, exp});
    endtask

    initial begin
        int got;
        int seen;
        rst      = 1'b1;
        res_data = '0;
        res_wren = 1'b0;
        wr_full  = 1'b0;
        step();
        step();
        check_eq("rst_wr_en",    wr_en,    0);
        check_eq("rst_wr_data",  wr_data,  0);
        check_eq("rst_seq",      seq,      0);
        check_eq("rst_overflow", overflow, 0);
        check_eq("rst_buf_full", buf_full, 0);

        // Single result: header two cycles after the push, data one cycle later.
        rst = 1'b0;
        step();
        res_data = 48'h5; res_wren = 1'b1;
        step();
        res_wren = 1'b0;
        check_eq("single_e0_wr_en", wr_en, 0);
        step();
        check_eq("single_e1_wr_en", wr_en, 0);
        step();
        check_eq("single_hdr_en",   wr_en,   1);
        check_eq("single_hdr_data", wr_data, 48'hA5_0000_000000);
        step();
        check_eq("single_dat_en",   wr_en,   1);
        check_eq("single_dat_data", wr_data, 48'h5);
        check_eq("single_seq",      seq,     1);
        step();
        check_eq("single_idle_en",  wr_en,   0);

        // Back-pressure during DATA.
        res_data = 48'h5; res_wren = 1'b1;
        step();
        res_wren = 1'b0;
        step();
        step();
        check_eq("bp_hdr_en",   wr_en,   1);
        check_eq("bp_hdr_data", wr_data, hdr(16'd1));
        wr_full = 1'b1;
        seen = 0;
        for (int i = 0; i < 5; i++) begin
            step();
            if (wr_en) seen++;
        end
        check_eq("bp_stall_wr_en", seen, 0);
        wr_full = 1'b0;
        step();
        check_eq("bp_dat_en",   wr_en,   1);
        check_eq("bp_dat_data", wr_data, 48'h5);
        check_eq("bp_seq",      seq,     2);

        // Overflow: five pushes into a four-entry buffer while downstream is full.
        wr_full = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            res_data = 48'(10 + k); res_wren = 1'b1;
            step();
            if (k == 3) check_eq("ovf_full_after3", buf_full, 0);
            if (k == 4) begin
                check_eq("ovf_full_after4", buf_full, 1);
                check_eq("ovf_flag_after4", overflow, 0);
            end
        end
        res_wren = 1'b0;
        step();
        check_eq("ovf_flag_after5", overflow, 1);
        check_eq("ovf_full_hold",   buf_full, 1);
        wr_full = 1'b0;
        collect(8, 40, got);
        check_eq("ovf_pkt_count", got, 8);
        for (int i = 0; i < 4; i++) begin
            check_pkt("ovf_hdr", 2*i,     hdr(16'(2 + i)));
            check_pkt("ovf_dat", 2*i + 1, 48'(11 + i));
        end
        step();
        check_eq("ovf_sticky",     overflow, 1);
        check_eq("ovf_drained",    buf_full, 0);
        check_eq("ovf_no_extra",   wr_en,    0);

        // Push while full in the same cycle as a DATA pop.
        rst = 1'b1;
        step();
        rst = 1'b0;
        check_eq("rst2_overflow", overflow, 0);
        wr_full = 1'b1;
        for (int k = 0; k < 4; k++) begin
            res_data = 48'(21 + k); res_wren = 1'b1;
            step();
        end
        res_wren = 1'b0;
        check_eq("pp_full", buf_full, 1);
        wr_full = 1'b0;
        step();
        step();
        check_eq("pp_hdr_data", wr_data, hdr(16'd0));
        res_data = 48'd25; res_wren = 1'b1;
        step();
        res_wren = 1'b0;
        check_eq("pp_dat_data", wr_data, 48'd21);
        check_eq("pp_full_kept", buf_full, 1);
        check_eq("pp_no_ovf",    overflow, 0);
        collect(8, 40, got);
        check_eq("pp_pkt_count", got, 8);
        for (int i = 0; i < 4; i++) begin
            check_pkt("pp_hdr", 2*i,     hdr(16'(1 + i)));
            check_pkt("pp_dat", 2*i + 1, 48'(22 + i));
        end

        // Sequence wrap.
        force dut.seq = 16'hFFFF;
        #1;
        release dut.seq;
        check_eq("wrap_seq_forced", seq, 16'hFFFF);
        res_data = 48'd31; res_wren = 1'b1;
        step();
        res_data = 48'd32;
        step();
        res_wren = 1'b0;
        collect(4, 20, got);
        check_eq("wrap_pkt_count", got, 4);
        check_pkt("wrap_hdr_ffff", 0, hdr(16'hFFFF));
        check_pkt("wrap_dat0",     1, 48'd31);
        check_pkt("wrap_hdr_0000", 2, hdr(16'h0000));
        check_pkt("wrap_dat1",     3, 48'd32);

        // Reset right after a header abandons the data packet; res_wren during rst is ignored.
        res_data = 48'd7; res_wren = 1'b1;
        step();
        res_wren = 1'b0;
        step();
        step();
        check_eq("mid_hdr_en",   wr_en,   1);
        check_eq("mid_hdr_data", wr_data, hdr(16'd1));
        rst = 1'b1; res_data = 48'd99; res_wren = 1'b1;
        step();
        rst = 1'b0; res_wren = 1'b0;
        check_eq("mid_wr_en",    wr_en,    0);
        check_eq("mid_wr_data",  wr_data,  0);
        check_eq("mid_seq",      seq,      0);
        check_eq("mid_buf_full", buf_full, 0);
        seen = 0;
        for (int i = 0; i < 8; i++) begin
            step();
            if (wr_en) seen++;
        end
        check_eq("mid_no_packets", seen, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/calc_result_tx.md
CALC_RESULT_TX -- requirements
Module: calc_result_tx

Interface
REQ-001 The module SHALL have parameter RAH_PACKET_WIDTH, default 48, giving the result and output packet width in bits; legal values are 24 and above.
REQ-002 The module SHALL have parameter DEPTH, default 4, giving the number of result buffer entries; the value SHALL be a power of 2 and at least 2.
REQ-003 The module SHALL have parameter HDR_TAG, default 8'hA5, giving the tag byte placed in every header packet.
REQ-004 The module SHALL have one clock and a synchronous, active-high reset.
REQ-005 Port list, one per line (name, direction, width, meaning):
 clk  in  1  single clock, rising edge
 rst  in  1  synchronous active-high reset
 res_data  in  RAH_PACKET_WIDTH  result word from the upstream calc unit
 res_wren  in  1  one-cycle pulse; res_data is valid this cycle
 wr_full  in  1  downstream RAH write FIFO is full
 wr_data  out  RAH_PACKET_WIDTH  packet to the RAH write FIFO
 wr_en  out  1  write strobe; one packet per asserted cycle
 buf_full  out  1  result buffer holds DEPTH entries
 overflow  out  1  sticky flag: a result was dropped
 seq  out  16  sequence number of the next header to send

Function
REQ-006 The module SHALL write res_data into the result buffer on any cycle with res_wren=1 and buffer not full (after the pop in the same cycle has been taken into account).
REQ-007 When res_wren=1 and the buffer is full with no pop that cycle, the module SHALL drop the word and set overflow=1 on the next cycle; overflow SHALL stay set until rst.
REQ-008 When the buffer is full and a pop happens in the same cycle, the module SHALL accept the push, leave the count unchanged, and SHALL NOT set overflow.
REQ-009 The state machine SHALL have three states:
 IDLE: leave to HDR when the buffer is not empty and wr_full=0.
 HDR: drive wr_en=1 and wr_data={HDR_TAG, seq, zeros}, with the tag in the MSBs; then go to DATA.
 DATA: if wr_full=0, drive wr_en=1 and wr_data=the buffer head, pop the head, increment seq (wrapping 16'hFFFF to 0), and go to IDLE; if wr_full=1, stay in DATA with wr_en=0.
REQ-010 wr_en and wr_data SHALL be registered outputs.
REQ-011 wr_en SHALL never be asserted in a cycle whose registering edge sampled wr_full=1.
REQ-012 For each result, the header packet and data packet SHALL be issued in that order; the two packets may be separated only by wr_full stall cycles.
REQ-013 Minimum latency from res_wren (buffer empty, wr_full=0) to the header wr_en SHALL be 2 cycles; the data wr_en SHALL follow 1 cycle after the header.
REQ-014 Steady-state throughput SHALL be one result per 3 cycles.
REQ-015 The buffer SHALL be FIFO-ordered, with read and write pointers wrapping modulo DEPTH.
REQ-016 buf_full SHALL be combinational from the occupancy count and SHALL equal (count==DEPTH).

Reset
REQ-017 While rst=1, the module SHALL force: state=IDLE, wr_en=0, wr_data=0, seq=0, overflow=0, pointers=0, count=0, and buf_full=0.
REQ-018 A rst asserted between the HDR and DATA packets SHALL abandon the pending data packet; the contents of the buffer SHALL be discarded.
REQ-019 The module SHALL ignore res_wren in any cycle in which rst=1.

Structure
REQ-020 A shared package calc_pkg SHALL hold RAH_PACKET_WIDTH, HDR_TAG, and the state encoding (IDLE=2'd0, HDR=2'd1, DATA=2'd2).
REQ-021 The buffer SHALL be a single sub-module, calc_result_fifo, with parameters WIDTH and DEPTH and ports push, pop, din, dout, count, full, and empty; the state machine and seq counter SHALL stay in calc_result_tx.

Verification
REQ-022 Single result: after rst, res_data=48'h5, wr_full=0 -> wr_data=48'hA5_0000_000000 with wr_en=1 two cycles later, then 48'h5 on the next cycle; seq becomes 1.
REQ-023 Back-pressure: hold wr_full=1 during DATA for 5 cycles -> no wr_en during the stall; data 48'h5 is written on the first cycle after release.
REQ-024 Overflow: with wr_full=1, push 5 results (DEPTH=4) -> buf_full=1 after the 4th push; overflow=1 after the 5th; after release, exactly 4 header/data pairs are sent in push order.
REQ-025 Simultaneous push and pop while full: push during a DATA pop -> count stays 4 and overflow stays 0.
REQ-026 Seq wrap: preload 65535 results' worth of traffic (or force seq=16'hFFFF) -> next header carries seq 16'hFFFF, the following header carries 16'h0000.
REQ-027 Mid-packet reset: assert rst for 1 cycle right after a header -> no data packet is issued; wr_en=0, seq=0, and buf_full=0 on the next cycle.
